branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning result-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RVC, default 0, meaning compressed-instruction support (1 = 2-byte target alignment).
REQ-004 SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_vld / in_rdy  in / out  1 / 1  input handshake
- in_op  in  bru_op_t  NONE/JAL/JALR/BR/SYS
- in_func3  in  3  branch condition
- in_is_rvc  in  1  instruction is 16-bit
- in_pc, in_src1, in_src2, in_imm, in_csr  in  XLEN each  operands
- in_pred_taken  in  1  fetch prediction
- in_pred_pc  in  XLEN  predicted target
- out_vld / out_rdy  out / in  1 / 1  output handshake
- out_taken  out  1  resolved direction
- out_target  out  XLEN  redirect PC
- out_link  out  XLEN  rd write value
- out_mispred  out  1  redirect required
- out_misalign  out  1  instruction-address-misaligned exception
- cnt_br, cnt_mispred  out  CNT_W each  performance counters

Function
REQ-006 SHALL accept a request only when in_vld & in_rdy; in_rdy = queue not full & ~flush; no combinational path from out_rdy to in_rdy.
REQ-007 SHALL compute target:
- JALR: (src1+imm) & ~1
- SYS: csr
- JAL/BR: pc+imm
- all modulo 2^XLEN
REQ-008 SHALL compute taken:
- 1 for JAL/JALR/SYS
- BR by func3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; other codes not taken
- NONE: not taken
REQ-009 SHALL set link = pc + (in_is_rvc ? 2 : 4).
REQ-010 SHALL set misalign = taken & (RVC ? target[0] : |target[1:0]); misaligned entries report mispred=0.
REQ-011 SHALL set mispred = ~misalign & ((taken != pred_taken) | (taken & target != pred_pc)); a not-taken BR with pred_taken=0 never mispredicts.
REQ-012 SHALL register results: an accepted request appears on out_* at the earliest the next cycle; a request accepted while the queue was empty SHALL appear exactly one cycle later.
REQ-013 SHALL hold out_* stable while out_vld & ~out_rdy.
REQ-014 SHALL present queued entries in FIFO order, with the pointer wrapping modulo DEPTH.
REQ-015 SHALL allow push and pop in the same cycle when not full; when full, in_rdy=0 even if a pop occurs.
REQ-016 SHALL, on flush, empty the queue next cycle, drop any same-cycle input, and leave counters unchanged.
REQ-017 SHALL increment cnt_br on each out_vld & out_rdy with op != NONE, and cnt_mispred when that entry's mispred=1; both wrap at 2^CNT_W.

Reset
REQ-018 SHALL on rst asynchronously clear the queue, out_vld, all out_* fields and both counters to 0; in_rdy=1 from the first cycle after rst deasserts.
REQ-019 SHALL discard in-flight entries when rst asserts mid-operation; no output handshake occurs while rst is high.

Structure
REQ-020 SHALL take bru_op_t, the func3 constants and the result-entry struct from a shared package bru_pkg.
REQ-021 SHALL implement the queue as one sub-module, bru_result_fifo, parameterised by DEPTH and entry type; compute logic stays in the top.

Verification
REQ-022 SHALL cover: BR func3=100, src1=-1, src2=1, pc=0x1000, imm=0x20, pred_taken=0 -> next cycle out_taken=1, target=0x1020, mispred=1, cnt_mispred=1.
REQ-023 SHALL cover: JALR src1=0x2003, imm=0, RVC=0 -> target=0x2002, misalign=1, mispred=0; with RVC=1 -> misalign=0.
REQ-024 SHALL cover: out_rdy=0, three back-to-back requests, DEPTH=2 -> in_rdy low after two accepts; third accepted only after one pop; FIFO order preserved.
REQ-025 SHALL cover: flush while queue holds 2 entries and in_vld=1 -> out_vld=0 next cycle; counters unchanged; no entry emerges.
REQ-026 SHALL cover: XLEN=32, JAL pc=0xFFFFFFFC, imm=8, in_is_rvc=0 -> target=0x4, link=0x0 (wrap).
REQ-027 SHALL cover: rst asserted mid-stream with CNT_W=4 after 15 branches -> all outputs 0 immediately; after release, 17 branches -> cnt_br=1 (wrap).

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: operation encoding, branch
// condition codes and the result entry carried through the output queue.
package bru_pkg;

    // Widest datapath supported; result entries are sized for it.
    localparam int BRU_MAX_XLEN = 64;

    typedef enum logic [2:0] {
        BRU_NONE = 3'd0,
        BRU_JAL  = 3'd1,
        BRU_JALR = 3'd2,
        BRU_BR   = 3'd3,
        BRU_SYS  = 3'd4
    } bru_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        bru_op_t                 op;
        logic                    taken;
        logic                    mispred;
        logic                    misalign;
        logic [BRU_MAX_XLEN-1:0] target;
        logic [BRU_MAX_XLEN-1:0] link;
    } bru_entry_t;

endpackage

// File: rtl/bru_result_fifo.sv
// Small circular result queue. DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset; only occupancy is.
module bru_result_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_data,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointer and occupancy tracking; flush empties the queue next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves jumps, branches and system redirects, queues the results and
// keeps branch / misprediction performance counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int RVC   = 0,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  bru_op_t         in_op,
    input  logic [2:0]      in_func3,
    input  logic            in_is_rvc,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_csr,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_pc,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispred,
    output logic            out_misalign,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_mispred
);

    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            taken;
    logic            misalign;
    logic            mispred;
    bru_entry_t      wr_entry;
    bru_entry_t      head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    function automatic logic br_cond(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return sa < sb;
            F3_BGE:  return sa >= sb;
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Direction, target, link and prediction check for the incoming request.
    always_comb begin
        pc_imm   = in_pc + in_imm;
        jalr_sum = in_src1 + in_imm;
        target   = pc_imm;
        taken    = 1'b0;
        case (in_op)
            BRU_JAL:  taken = 1'b1;
            BRU_JALR: begin
                target = {jalr_sum[XLEN-1:1], 1'b0};
                taken  = 1'b1;
            end
            BRU_BR:   taken = br_cond(in_func3, in_src1, in_src2);
            BRU_SYS:  begin
                target = in_csr;
                taken  = 1'b1;
            end
            default:  taken = 1'b0;
        endcase
        link     = in_pc + (in_is_rvc ? XLEN'(2) : XLEN'(4));
        // With compressed support only bit 0 must be clear.
        misalign = taken & ((RVC != 0) ? target[0] : |target[1:0]);
        mispred  = ~misalign & ((taken != in_pred_taken) |
                                (taken & (target != in_pred_pc)));
    end

    // Pack the result into a full-width queue entry.
    always_comb begin
        wr_entry                    = '0;
        wr_entry.op                 = in_op;
        wr_entry.taken              = taken;
        wr_entry.mispred            = mispred;
        wr_entry.misalign           = misalign;
        wr_entry.target[XLEN-1:0]   = target;
        wr_entry.link[XLEN-1:0]     = link;
    end

    // in_rdy depends only on occupancy and flush, never on out_rdy.
    assign in_rdy  = ~full & ~flush;
    assign push    = in_vld & in_rdy;
    assign out_vld = ~empty;
    assign pop     = out_vld & out_rdy;

    bru_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (bru_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Outputs read as zero whenever no entry is presented.
    assign out_taken    = out_vld & head.taken;
    assign out_mispred  = out_vld & head.mispred;
    assign out_misalign = out_vld & head.misalign;
    assign out_target   = out_vld ? head.target[XLEN-1:0] : '0;
    assign out_link     = out_vld ? head.link[XLEN-1:0]   : '0;

    if (XLEN < BRU_MAX_XLEN) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{head.target[BRU_MAX_XLEN-1:XLEN],
                              head.link[BRU_MAX_XLEN-1:XLEN]};
    end

    // Count retired control-flow entries; a flush cycle leaves counters alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_br      <= '0;
            cnt_mispred <= '0;
        end else if (pop && !flush && head.op != BRU_NONE) begin
            cnt_br <= cnt_br + 1'b1;
            if (head.mispred) cnt_mispred <= cnt_mispred + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench: two instances (64-bit/RVC=0/32-bit counters and 32-bit/RVC=1/4-bit
// counters) driven from vector tables, hand sequences and random traffic.
`timescale 1ns/1ps
module tb_branch_resolve_unit;
    import bru_pkg::*;

    typedef struct packed {
        bru_op_t     op;
        logic [2:0]  f3;
        logic        rvc;
        logic [63:0] pc;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] imm;
        logic [63:0] csr;
        logic        pt;
        logic [63:0] ppc;
    } req_t;

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
        logic [63:0] link;
        logic        mispred;
        logic        misalign;
    } res_t;

    typedef struct {
        req_t rq;
        res_t ex;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, flush_a, a_vld, a_rdy, a_ordy, a_ovld, a_taken, a_mp, a_mis;
    logic [63:0] a_tgt, a_link;
    logic [31:0] a_cbr, a_cmp;
    req_t        ra;

    logic        rst_b, flush_b, b_vld, b_rdy, b_ordy, b_ovld, b_taken, b_mp, b_mis;
    logic [31:0] b_tgt, b_link;
    logic [3:0]  b_cbr, b_cmp;
    req_t        rb;

    branch_resolve_unit #(.XLEN(64), .DEPTH(2), .RVC(0), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a),
        .in_vld(a_vld), .in_rdy(a_rdy), .in_op(ra.op), .in_func3(ra.f3),
        .in_is_rvc(ra.rvc), .in_pc(ra.pc), .in_src1(ra.s1), .in_src2(ra.s2),
        .in_imm(ra.imm), .in_csr(ra.csr), .in_pred_taken(ra.pt), .in_pred_pc(ra.ppc),
        .out_vld(a_ovld), .out_rdy(a_ordy), .out_taken(a_taken), .out_target(a_tgt),
        .out_link(a_link), .out_mispred(a_mp), .out_misalign(a_mis),
        .cnt_br(a_cbr), .cnt_mispred(a_cmp)
    );

    branch_resolve_unit #(.XLEN(32), .DEPTH(2), .RVC(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b),
        .in_vld(b_vld), .in_rdy(b_rdy), .in_op(rb.op), .in_func3(rb.f3),
        .in_is_rvc(rb.rvc), .in_pc(rb.pc[31:0]), .in_src1(rb.s1[31:0]),
        .in_src2(rb.s2[31:0]), .in_imm(rb.imm[31:0]), .in_csr(rb.csr[31:0]),
        .in_pred_taken(rb.pt), .in_pred_pc(rb.ppc[31:0]),
        .out_vld(b_ovld), .out_rdy(b_ordy), .out_taken(b_taken), .out_target(b_tgt),
        .out_link(b_link), .out_mispred(b_mp), .out_misalign(b_mis),
        .cnt_br(b_cbr), .cnt_mispred(b_cmp)
    );

    int checks = 0;
    int errors = 0;
    int exp_br_a = 0, exp_mp_a = 0, exp_br_b = 0, exp_mp_b = 0;
    vec_t tbl[12];
    vec_t q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour: resolution rules applied with plain arithmetic.
    function automatic res_t model(req_t r, int xlen, bit rvc);
        res_t e;
        logic [63:0] m, a, b;
        longint sa, sb;
        m  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = r.s1 & m;
        b  = r.s2 & m;
        sa = (xlen == 64) ? $signed(a) : longint'($signed(a[31:0]));
        sb = (xlen == 64) ? $signed(b) : longint'($signed(b[31:0]));
        e.taken  = 1'b0;
        e.target = (r.pc + r.imm) & m;
        case (r.op)
            BRU_JAL:  e.taken = 1'b1;
            BRU_JALR: begin e.target = ((r.s1 + r.imm) & m) & ~64'd1; e.taken = 1'b1; end
            BRU_SYS:  begin e.target = r.csr & m; e.taken = 1'b1; end
            BRU_BR: begin
                case (r.f3)
                    3'd0: e.taken = (a == b);
                    3'd1: e.taken = (a != b);
                    3'd4: e.taken = (sa < sb);
                    3'd5: e.taken = (sa >= sb);
                    3'd6: e.taken = (a < b);
                    3'd7: e.taken = (a >= b);
                    default: e.taken = 1'b0;
                endcase
            end
            default: e.taken = 1'b0;
        endcase
        e.link     = (r.pc + (r.rvc ? 64'd2 : 64'd4)) & m;
        e.misalign = e.taken && (rvc ? e.target[0] : (e.target[1:0] != 2'b00));
        e.mispred  = !e.misalign && ((e.taken != r.pt) ||
                                     (e.taken && e.target != (r.ppc & m)));
        return e;
    endfunction

    function automatic req_t mk(bru_op_t op, logic [2:0] f3, logic rvc, logic [63:0] pc,
                                logic [63:0] s1, logic [63:0] s2, logic [63:0] imm,
                                logic [63:0] csr, logic pt, logic [63:0] ppc);
        req_t r;
        r.op = op; r.f3 = f3; r.rvc = rvc; r.pc = pc; r.s1 = s1; r.s2 = s2;
        r.imm = imm; r.csr = csr; r.pt = pt; r.ppc = ppc;
        return r;
    endfunction

    function automatic res_t ex(logic tk, logic [63:0] tgt, logic [63:0] lnk,
                                logic mp, logic mis);
        res_t e;
        e.taken = tk; e.target = tgt; e.link = lnk; e.mispred = mp; e.misalign = mis;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        res_t e;
        r.op  = bru_op_t'($urandom_range(0, 4));
        r.f3  = 3'($urandom_range(0, 7));
        r.rvc = 1'($urandom_range(0, 1));
        r.pc  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r.pc &= ~64'd3;
        r.s1  = {$urandom, $urandom};
        r.s2  = ($urandom_range(0, 3) == 0) ? r.s1 : {$urandom, $urandom};
        r.imm = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r.imm &= ~64'd3;
        r.csr = {$urandom, $urandom};
        r.pt  = 1'($urandom_range(0, 1));
        r.ppc = '0;
        e     = model(r, 64, 1'b0);
        r.ppc = ($urandom_range(0, 1) == 1) ? e.target : {$urandom, $urandom};
        return r;
    endfunction

    task automatic check_a(string t, req_t r, res_t e);
        chk({t, ".vld"},      64'(a_ovld),  64'd1);
        chk({t, ".taken"},    64'(a_taken), 64'(e.taken));
        if (r.op != BRU_NONE) chk({t, ".target"}, a_tgt, e.target);
        chk({t, ".link"},     a_link,       e.link);
        chk({t, ".mispred"},  64'(a_mp),    64'(e.mispred));
        chk({t, ".misalign"}, 64'(a_mis),   64'(e.misalign));
    endtask

    task automatic check_b(string t, res_t e);
        chk({t, ".vld"},      64'(b_ovld),  64'd1);
        chk({t, ".taken"},    64'(b_taken), 64'(e.taken));
        chk({t, ".target"},   64'(b_tgt),   e.target);
        chk({t, ".link"},     64'(b_link),  e.link);
        chk({t, ".mispred"},  64'(b_mp),    64'(e.mispred));
        chk({t, ".misalign"}, 64'(b_mis),   64'(e.misalign));
    endtask

    // Push one request into B, check it the next cycle, let it pop.
    task automatic b_send(string t, req_t r);
        rb = r; b_vld = 1'b1; b_ordy = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        check_b(t, model(r, 32, 1'b1));
        if (r.op != BRU_NONE) begin
            exp_br_b++;
            if (model(r, 32, 1'b1).mispred) exp_mp_b++;
        end
        @(negedge clk);
    endtask

    // Continuous one-per-cycle stream of identical branches into B.
    task automatic b_stream(int n, req_t r);
        rb = r; b_ordy = 1'b1; b_vld = 1'b1;
        repeat (n) @(negedge clk);
        b_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        req_t r, r1, r2, r3;
        res_t e;
        vec_t v;
        bit   can_push, do_pop;

        tbl[0]  = '{mk(BRU_BR,   3'b100, 0, 64'h1000, '1, 64'd1, 64'h20, 0, 0, 0),
                    ex(1, 64'h1020, 64'h1004, 1, 0)};
        tbl[1]  = '{mk(BRU_JALR, 3'b000, 0, 64'h3000, 64'h2003, 0, 0, 0, 1, 64'h2002),
                    ex(1, 64'h2002, 64'h3004, 0, 1)};
        tbl[2]  = '{mk(BRU_BR,   3'b000, 0, 64'h100, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 64'hF8),
                    ex(1, 64'hF8, 64'h104, 0, 0)};
        tbl[3]  = '{mk(BRU_BR,   3'b001, 0, 64'h200, 64'd7, 64'd7, 64'h40, 0, 0, 0),
                    ex(0, 64'h240, 64'h204, 0, 0)};
        tbl[4]  = '{mk(BRU_BR,   3'b110, 0, 64'h400, '1, 64'd1, 64'h10, 0, 1, 64'h410),
                    ex(0, 64'h410, 64'h404, 1, 0)};
        tbl[5]  = '{mk(BRU_BR,   3'b101, 0, 64'h500, '1, 64'd1, 64'h4, 0, 0, 0),
                    ex(0, 64'h504, 64'h504, 0, 0)};
        tbl[6]  = '{mk(BRU_BR,   3'b111, 0, 64'h600, '1, 64'd1, 64'h100, 0, 1, 64'h704),
                    ex(1, 64'h700, 64'h604, 1, 0)};
        tbl[7]  = '{mk(BRU_SYS,  3'b000, 0, 64'h700, 0, 0, 0, 64'h8000_0000_0000_0100, 0, 0),
                    ex(1, 64'h8000_0000_0000_0100, 64'h704, 1, 0)};
        tbl[8]  = '{mk(BRU_BR,   3'b010, 0, 64'h800, 0, 0, 64'h8, 0, 0, 0),
                    ex(0, 64'h808, 64'h804, 0, 0)};
        tbl[9]  = '{mk(BRU_JAL,  3'b000, 1, 64'h900, 0, 0, 64'h22, 0, 1, 64'h922),
                    ex(1, 64'h922, 64'h902, 0, 1)};
        tbl[10] = '{mk(BRU_NONE, 3'b000, 0, 64'hA00, 0, 0, 0, 0, 0, 0),
                    ex(0, 64'hA00, 64'hA04, 0, 0)};
        tbl[11] = '{mk(BRU_BR,   3'b110, 0, 64'hB00, 64'd1, '1, 64'h8, 0, 1, 64'hB08),
                    ex(1, 64'hB08, 64'hB04, 0, 0)};

        rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
        a_vld = 1'b0; b_vld = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
        ra = '0; rb = '0;
        repeat (2) @(negedge clk);
        chk("rst.a_vld", 64'(a_ovld), 0);
        chk("rst.a_cbr", 64'(a_cbr), 0);
        chk("rst.b_vld", 64'(b_ovld), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("rel.a_rdy", 64'(a_rdy), 1);
        chk("rel.b_rdy", 64'(b_rdy), 1);
        chk("rel.a_cmp", 64'(a_cmp), 0);

        // Vector table on the 64-bit instance, one request at a time.
        for (int i = 0; i < 12; i++) begin
            ra = tbl[i].rq; a_vld = 1'b1;
            @(negedge clk);
            a_vld = 1'b0;
            check_a($sformatf("vec%0d", i), tbl[i].rq, tbl[i].ex);
            if (tbl[i].rq.op != BRU_NONE) begin
                exp_br_a++;
                if (tbl[i].ex.mispred) exp_mp_a++;
            end
            @(negedge clk);
            chk($sformatf("vec%0d.drain", i), 64'(a_ovld), 0);
            chk($sformatf("vec%0d.cnt_br", i), 64'(a_cbr), 64'(exp_br_a));
            chk($sformatf("vec%0d.cnt_mp", i), 64'(a_cmp), 64'(exp_mp_a));
        end

        // Backpressure: queue of two fills, third waits for one pop.
        r1 = mk(BRU_JAL, 0, 0, 64'h1100, 0, 0, 64'h40, 0, 1, 64'h1140);
        r2 = mk(BRU_JAL, 0, 0, 64'h1200, 0, 0, 64'h40, 0, 1, 64'h1240);
        r3 = mk(BRU_JAL, 0, 0, 64'h1300, 0, 0, 64'h40, 0, 1, 64'h1340);
        a_ordy = 1'b0;
        ra = r1; a_vld = 1'b1;
        chk("bp.rdy0", 64'(a_rdy), 1);
        @(negedge clk);
        ra = r2;
        chk("bp.rdy1", 64'(a_rdy), 1);
        chk("bp.head1", a_link, 64'h1104);
        @(negedge clk);
        ra = r3;
        chk("bp.full", 64'(a_rdy), 0);
        @(negedge clk);
        chk("bp.full_stall", 64'(a_rdy), 0);
        chk("bp.hold", a_link, 64'h1104);
        a_ordy = 1'b1;
        @(negedge clk);
        chk("bp.head2", a_link, 64'h1204);
        chk("bp.rdy_after_pop", 64'(a_rdy), 1);
        a_ordy = 1'b0;
        @(negedge clk);
        a_vld = 1'b0;
        chk("bp.head2_hold", a_link, 64'h1204);
        chk("bp.full_again", 64'(a_rdy), 0);
        a_ordy = 1'b1;
        @(negedge clk);
        chk("bp.head3", a_link, 64'h1304);
        chk("bp.head3_tgt", a_tgt, 64'h1340);
        @(negedge clk);
        chk("bp.empty", 64'(a_ovld), 0);
        exp_br_a += 3;
        chk("bp.cnt_br", 64'(a_cbr), 64'(exp_br_a));

        // Flush with two entries queued and a request on the input.
        a_ordy = 1'b0;
        ra = r1; a_vld = 1'b1;
        @(negedge clk);
        ra = r2;
        @(negedge clk);
        ra = r3; flush_a = 1'b1;
        chk("fl.rdy", 64'(a_rdy), 0);
        @(negedge clk);
        flush_a = 1'b0; a_vld = 1'b0;
        chk("fl.vld", 64'(a_ovld), 0);
        chk("fl.cnt_br", 64'(a_cbr), 64'(exp_br_a));
        chk("fl.cnt_mp", 64'(a_cmp), 64'(exp_mp_a));
        a_ordy = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl.nothing", 64'(a_ovld), 0);
        chk("fl.cnt_after", 64'(a_cbr), 64'(exp_br_a));

        // Random traffic against a queue-level reference.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            if (q.size() > 0) check_a($sformatf("rnd%0d", c), q[0].rq, q[0].ex);
            else chk($sformatf("rnd%0d.vld", c), 64'(a_ovld), 0);
            chk($sformatf("rnd%0d.rdy", c), 64'(a_rdy), 64'(q.size() < 2));
            chk($sformatf("rnd%0d.cnt_br", c), 64'(a_cbr), 64'(exp_br_a));
            chk($sformatf("rnd%0d.cnt_mp", c), 64'(a_cmp), 64'(exp_mp_a));
            r = rand_req();
            ra = r;
            a_vld  = ($urandom_range(0, 3) != 0);
            a_ordy = ($urandom_range(0, 2) != 0);
            can_push = a_vld && (q.size() < 2);
            do_pop   = (q.size() > 0) && a_ordy;
            if (do_pop) begin
                v = q.pop_front();
                if (v.rq.op != BRU_NONE) begin
                    exp_br_a++;
                    if (v.ex.mispred) exp_mp_a++;
                end
            end
            if (can_push) q.push_back('{r, model(r, 64, 1'b0)});
            @(negedge clk);
        end
        a_vld = 1'b0;

        // 32-bit instance with compressed support.
        r = mk(BRU_JALR, 0, 0, 64'h4000, 64'h2003, 0, 0, 0, 1, 64'h2002);
        b_send("rvc_jalr", r);
        r = mk(BRU_JAL, 0, 0, 64'hFFFF_FFFC, 0, 0, 64'd8, 0, 1, 64'h4);
        rb = r; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        chk("wrap.target", 64'(b_tgt), 64'h4);
        chk("wrap.link", 64'(b_link), 64'h0);
        chk("wrap.misalign", 64'(b_mis), 0);
        exp_br_b++;
        @(negedge clk);
        chk("rvc_jalr.misalign_after", 64'(b_cbr), 64'(exp_br_b));

        // Thirteen more correctly predicted branches: 15 in total.
        r = mk(BRU_BR, 3'b000, 0, 64'h40, 64'd3, 64'd3, 64'h10, 0, 1, 64'h50);
        b_stream(13, r);
        exp_br_b += 13;
        chk("b15.cnt_br", 64'(b_cbr), 64'(exp_br_b & 15));
        chk("b15.cnt_mp", 64'(b_cmp), 64'(exp_mp_b & 15));

        // Leave one entry in flight, then reset mid-cycle.
        b_ordy = 1'b0; rb = r; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        chk("inflight.vld", 64'(b_ovld), 1);
        #2 rst_b = 1'b1;
        #1;
        chk("mrst.vld", 64'(b_ovld), 0);
        chk("mrst.taken", 64'(b_taken), 0);
        chk("mrst.target", 64'(b_tgt), 0);
        chk("mrst.link", 64'(b_link), 0);
        chk("mrst.flags", 64'({b_mp, b_mis}), 0);
        chk("mrst.cnt_br", 64'(b_cbr), 0);
        chk("mrst.cnt_mp", 64'(b_cmp), 0);
        b_ordy = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("mrel.rdy", 64'(b_rdy), 1);
        chk("mrel.vld", 64'(b_ovld), 0);

        // Seventeen mispredicted branches wrap both 4-bit counters to 1.
        r = mk(BRU_BR, 3'b000, 0, 64'h40, 64'd3, 64'd3, 64'h10, 0, 0, 64'h0);
        b_stream(17, r);
        chk("b17.cnt_br", 64'(b_cbr), 64'd1);
        chk("b17.cnt_mp", 64'(b_cmp), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
